gc_controller_responder: RTL and testbench



---
 rtl/gc_pkg.sv | 39 +++
 rtl/gc_controller_responder_if.sv | 28 ++
 rtl/gc_line_sync.sv | 40 ++++
 rtl/gc_controller_responder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_gc_controller_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/gc_pkg.sv
// Shared constants, state encoding and report packing for the GameCube
// controller-side link.
package gc_pkg;

    localparam logic [7:0]  CMD_IDENTIFY     = 8'h00;
    localparam logic [7:0]  CMD_POLL         = 8'h40;
    localparam logic [7:0]  POLL_MODE        = 8'h03;
    localparam logic [23:0] ID_REPLY         = 24'h090003;

    // Frame lengths in bits; receive lengths include the stop bit.
    localparam int IDENT_FRAME_BITS = 9;
    localparam int POLL_FRAME_BITS  = 25;
    localparam int ID_REPLY_BITS    = 24;
    localparam int REPORT_BITS      = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_LOW  = 3'd1,
        RX_HIGH = 3'd2,
        TX_BIT  = 3'd3,
        TX_STOP = 3'd4,
        RECOVER = 3'd5,
        FAULT   = 3'd6
    } gc_state_e;

    // Pack the pad inputs into the 64-bit poll report, MSB transmitted first.
    function automatic logic [63:0] build_report(
        input logic [11:0] btn,
        input logic [7:0]  jx,
        input logic [7:0]  jy,
        input logic [7:0]  cx,
        input logic [7:0]  cy,
        input logic [7:0]  lt,
        input logic [7:0]  rt
    );
        return {3'b000, btn[4:0], 1'b1, btn[11:5], jx, jy, cx, cy, lt, rt};
    endfunction

endpackage

// File: rtl/gc_controller_responder_if.sv
// Line and pad-side signals of the controller responder. The responder
// takes the slave view; the surrounding logic (or a bench) takes the master.
interface gc_controller_responder_if;

    logic        data_in;
    logic        data_oe;
    logic [11:0] buttons;
    logic [7:0]  joy_x;
    logic [7:0]  joy_y;
    logic [7:0]  cstick_x;
    logic [7:0]  cstick_y;
    logic [7:0]  l_trig;
    logic [7:0]  r_trig;
    logic        rumble;
    logic        poll_strobe;
    logic        cmd_error;

    modport slave (
        input  data_in, buttons, joy_x, joy_y, cstick_x, cstick_y, l_trig, r_trig,
        output data_oe, rumble, poll_strobe, cmd_error
    );

    modport master (
        output data_in, buttons, joy_x, joy_y, cstick_x, cstick_y, l_trig, r_trig,
        input  data_oe, rumble, poll_strobe, cmd_error
    );

endinterface

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the raw open-drain line plus registered
// one-cycle rise/fall pulses taken from the synchronized level. The idle
// line is high, so every stage resets to 1 to avoid a false edge.
module gc_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Synchronize the line and register edge pulses off the clean level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/gc_controller_responder.sv
// Controller-side end of the GameCube single-wire link: decodes console
// commands (identify / poll) from pulse-width bit cells and answers on the
// same open-drain wire with the device ID or the 64-bit pad report.
module gc_controller_responder
    import gc_pkg::*;
#(
    parameter int CLKS_PER_US   = 100,
    parameter int TURNAROUND_US = 3,
    parameter int MAX_LOW_US    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    gc_controller_responder_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_LOW_US * CLKS_PER_US + 1);

    localparam logic [CNT_W-1:0] ONE_US       = CNT_W'(CLKS_PER_US);
    localparam logic [CNT_W-1:0] TWO_US       = CNT_W'(2 * CLKS_PER_US);
    localparam logic [CNT_W-1:0] THREE_US     = CNT_W'(3 * CLKS_PER_US);
    localparam logic [CNT_W-1:0] TURN_CNT     = CNT_W'(TURNAROUND_US * CLKS_PER_US);
    localparam logic [CNT_W-1:0] LOW_MAX      = CNT_W'(MAX_LOW_US * CLKS_PER_US);
    localparam logic [CNT_W-1:0] CELL_LAST    = CNT_W'(4 * CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] STOP_LAST    = CNT_W'(CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(2 * CLKS_PER_US - 1);
    localparam logic [4:0]       BIT_CNT_MAX  = 5'd31;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic w_level;
    logic w_rise;
    logic w_fall;

    gc_state_e r_state;
    gc_state_e w_state_next;

    logic [CNT_W-1:0] r_low_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_cell_cnt;
    logic [4:0]       r_bit_cnt;
    logic [24:0]      r_rx_shift;
    logic [63:0]      r_tx_shift;
    logic [6:0]       r_tx_idx;
    logic [6:0]       r_tx_last;
    logic             r_data_oe;
    logic             r_rumble;
    logic             r_poll_strobe;
    logic             r_cmd_error;

    logic w_rx_bit;
    logic w_is_ident;
    logic w_is_poll;
    logic w_ident_start;
    logic w_poll_start;
    logic w_cmd_error;
    logic w_oe_next;
    logic w_cell_end;
    logic w_last_bit;

    gc_line_sync u_line_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (bus.data_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Short low phase is a 1, long low phase (two cell-quarters or more) is a 0.
    assign w_rx_bit   = (r_low_cnt >= TWO_US) ? 1'b0 : 1'b1;

    // Frame classification; the last received bit is the stop bit and must be 1.
    assign w_is_ident = (r_bit_cnt == 5'(IDENT_FRAME_BITS))
                        && (r_rx_shift[8:1] == CMD_IDENTIFY)
                        && r_rx_shift[0];
    assign w_is_poll  = (r_bit_cnt == 5'(POLL_FRAME_BITS))
                        && (r_rx_shift[24:17] == CMD_POLL)
                        && (r_rx_shift[16:9] == POLL_MODE)
                        && r_rx_shift[0];

    assign w_cell_end = (r_cell_cnt == CELL_LAST);
    assign w_last_bit = (r_tx_idx == r_tx_last);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, line drive and event decode
    always_comb begin
        w_state_next  = r_state;
        w_oe_next     = 1'b0;
        w_ident_start = 1'b0;
        w_poll_start  = 1'b0;
        w_cmd_error   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_next = RX_LOW;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RX_LOW: begin
                if (w_rise) begin
                    w_state_next = RX_HIGH;
                end else if (r_low_cnt >= LOW_MAX) begin
                    w_state_next = FAULT;
                    w_cmd_error  = 1'b1;
                end else begin
                    w_state_next = RX_LOW;
                end
            end
            RX_HIGH: begin
                if (r_bit_cnt > 5'(POLL_FRAME_BITS)) begin
                    w_state_next = FAULT;
                    w_cmd_error  = 1'b1;
                end else if (w_fall) begin
                    w_state_next = RX_LOW;
                end else if (r_high_cnt >= TURN_CNT) begin
                    if (w_is_ident) begin
                        w_state_next  = TX_BIT;
                        w_ident_start = 1'b1;
                    end else if (w_is_poll) begin
                        w_state_next  = TX_BIT;
                        w_poll_start  = 1'b1;
                    end else begin
                        w_state_next  = IDLE;
                        w_cmd_error   = 1'b1;
                    end
                end else begin
                    w_state_next = RX_HIGH;
                end
            end
            TX_BIT: begin
                w_oe_next = (r_cell_cnt < (r_tx_shift[63] ? ONE_US : THREE_US));
                if (w_cell_end && w_last_bit) begin
                    w_state_next = TX_STOP;
                end else begin
                    w_state_next = TX_BIT;
                end
            end
            TX_STOP: begin
                w_oe_next = (r_cell_cnt < ONE_US);
                if (r_cell_cnt == STOP_LAST) begin
                    w_state_next = RECOVER;
                end else begin
                    w_state_next = TX_STOP;
                end
            end
            RECOVER: begin
                if (r_cell_cnt == RECOVER_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RECOVER;
                end
            end
            FAULT: begin
                // Require the level to still be high so an exactly-threshold
                // high gap inside a runaway frame does not end the fault.
                if ((r_high_cnt >= TURN_CNT) && w_level) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = FAULT;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Receive counters, shift registers and reply bit sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
            r_cell_cnt <= '0;
            r_bit_cnt  <= 5'd0;
            r_rx_shift <= 25'd0;
            r_tx_shift <= 64'd0;
            r_tx_idx   <= 7'd0;
            r_tx_last  <= 7'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_low_cnt  <= '0;
                    r_high_cnt <= '0;
                    r_cell_cnt <= '0;
                    r_bit_cnt  <= 5'd0;
                    r_rx_shift <= 25'd0;
                end
                RX_LOW: begin
                    r_high_cnt <= '0;
                    if (w_rise) begin
                        r_rx_shift <= {r_rx_shift[23:0], w_rx_bit};
                        r_bit_cnt  <= (r_bit_cnt == BIT_CNT_MAX) ? r_bit_cnt : r_bit_cnt + 5'd1;
                    end else begin
                        r_low_cnt  <= sat_inc(r_low_cnt);
                    end
                end
                RX_HIGH: begin
                    if (w_state_next == FAULT) begin
                        r_high_cnt <= '0;
                    end else if (w_fall) begin
                        r_low_cnt  <= '0;
                    end else begin
                        r_high_cnt <= sat_inc(r_high_cnt);
                    end
                    if (w_ident_start) begin
                        r_tx_shift <= {ID_REPLY, 40'h0};
                        r_tx_last  <= 7'(ID_REPLY_BITS - 1);
                        r_tx_idx   <= 7'd0;
                        r_cell_cnt <= '0;
                    end else if (w_poll_start) begin
                        // Pad inputs are sampled exactly once, here.
                        r_tx_shift <= build_report(bus.buttons, bus.joy_x, bus.joy_y,
                                                   bus.cstick_x, bus.cstick_y,
                                                   bus.l_trig, bus.r_trig);
                        r_tx_last  <= 7'(REPORT_BITS - 1);
                        r_tx_idx   <= 7'd0;
                        r_cell_cnt <= '0;
                    end
                end
                TX_BIT: begin
                    if (w_cell_end) begin
                        r_cell_cnt <= '0;
                        r_tx_shift <= {r_tx_shift[62:0], 1'b0};
                        r_tx_idx   <= r_tx_idx + 7'd1;
                    end else begin
                        r_cell_cnt <= r_cell_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (r_cell_cnt == STOP_LAST) begin
                        r_cell_cnt <= '0;
                    end else begin
                        r_cell_cnt <= r_cell_cnt + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    r_cell_cnt <= r_cell_cnt + CNT_W'(1);
                end
                FAULT: begin
                    if (w_level) begin
                        r_high_cnt <= sat_inc(r_high_cnt);
                    end else begin
                        r_high_cnt <= '0;
                    end
                end
                default: begin
                    r_cell_cnt <= '0;
                end
            endcase
        end
    end

    // Registered outputs: line drive, rumble flag and event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_oe     <= 1'b0;
            r_rumble      <= 1'b0;
            r_poll_strobe <= 1'b0;
            r_cmd_error   <= 1'b0;
        end else begin
            r_data_oe     <= w_oe_next;
            r_poll_strobe <= w_poll_start;
            r_cmd_error   <= w_cmd_error;
            if (w_poll_start) begin
                r_rumble <= r_rx_shift[1];
            end
        end
    end

    assign bus.data_oe     = r_data_oe;
    assign bus.rumble      = r_rumble;
    assign bus.poll_strobe = r_poll_strobe;
    assign bus.cmd_error   = r_cmd_error;

endmodule

// File: tb/tb_gc_controller_responder.sv
// Directed bench for gc_controller_responder: plays the console side of the
// wire, decodes the reply pulse widths and compares against hand-computed
// replies. Timing is scaled to 10 clocks per microsecond to keep runs short.
module tb_gc_controller_responder;

    localparam int CPU  = 10;
    localparam int TURN = 3 * CPU;

    logic clk = 1'b0;
    logic reset;
    logic host_low;

    gc_controller_responder_if bus ();

    // Open-drain wire: low if either side pulls it down.
    assign bus.data_in = ~(host_low | bus.data_oe);

    gc_controller_responder #(
        .CLKS_PER_US   (CPU),
        .TURNAROUND_US (3),
        .MAX_LOW_US    (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;
    int n_err    = 0;
    int n_oe     = 0;

    // Count output pulses and line-drive cycles
    always @(negedge clk) begin
        if (bus.poll_strobe === 1'b1) n_strobe <= n_strobe + 1;
        if (bus.cmd_error === 1'b1)   n_err    <= n_err + 1;
        if (bus.data_oe === 1'b1)     n_oe     <= n_oe + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pad(input logic [11:0] b, input logic [7:0] jx, input logic [7:0] jy,
                           input logic [7:0] cx, input logic [7:0] cy,
                           input logic [7:0] lt, input logic [7:0] rt);
        bus.buttons  = b;
        bus.joy_x    = jx;
        bus.joy_y    = jy;
        bus.cstick_x = cx;
        bus.cstick_y = cy;
        bus.l_trig   = lt;
        bus.r_trig   = rt;
    endtask

    task automatic send_bit(input logic b);
        int lo;
        lo = b ? CPU : 3 * CPU;
        host_low = 1'b1;
        repeat (lo) @(negedge clk);
        host_low = 1'b0;
        repeat (4 * CPU - lo) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
        send_bit(1'b1);
    endtask

    // Decode reply cells by low width; bad counts malformed cells.
    task automatic capture(input int nbits, input bit scramble, output logic [63:0] val,
                           output int bad, output int stop_low, output int lat);
        int t;
        int w;
        val = 64'd0; bad = 0; stop_low = 0; lat = 0; t = 0;
        while (bus.data_oe !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        lat = t;
        if (bus.data_oe !== 1'b1) begin
            bad = 1;
            lat = -1;
            return;
        end
        if (scramble) set_pad(12'hFFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
        for (int i = 0; i <= nbits; i++) begin
            w = 0;
            while (bus.data_oe === 1'b1 && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (i == nbits) begin
                stop_low = w;
            end else begin
                if (w == CPU)          val = {val[62:0], 1'b1};
                else if (w == 3 * CPU) val = {val[62:0], 1'b0};
                else                   bad++;
                t = 0;
                while (bus.data_oe !== 1'b1 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                if (w + t != 4 * CPU) bad++;
            end
        end
    endtask

    task automatic expect_reply(input string tag, input int nbits, input logic [63:0] exp,
                                input bit scramble, output int lat);
        logic [63:0] v;
        int bad;
        int sl;
        int o0;
        capture(nbits, scramble, v, bad, sl, lat);
        chk({tag, "_data"}, v, exp);
        chk({tag, "_cells"}, 64'(bad), 64'd0);
        chk({tag, "_stop"}, 64'(sl), 64'(CPU));
        o0 = n_oe;
        repeat (4 * CPU) @(negedge clk);
        chk({tag, "_quiet"}, 64'(n_oe - o0), 64'd0);
    endtask

    int lat;
    int s0;
    int e0;
    int o0;
    int first;
    int t;

    initial begin
        reset    = 1'b1;
        host_low = 1'b0;
        set_pad(12'h001, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        chk("rst_data_oe", bus.data_oe, 64'd0);
        chk("rst_rumble", bus.rumble, 64'd0);
        chk("rst_poll_strobe", bus.poll_strobe, 64'd0);
        chk("rst_cmd_error", bus.cmd_error, 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Poll with rumble off; inputs are changed once the reply has begun.
        s0 = n_strobe; e0 = n_err;
        send_frame(32'h0040_0300, 24);
        expect_reply("poll1", 64, 64'h0180_807F_0000_0000, 1'b1, lat);
        chk("poll1_latency_window", 64'((lat + 3 * CPU >= TURN) && (lat + 3 * CPU <= TURN + 8)), 64'd1);
        chk("poll1_strobe_count", 64'(n_strobe - s0), 64'd1);
        chk("poll1_rumble", bus.rumble, 64'd0);
        chk("poll1_no_error", 64'(n_err - e0), 64'd0);

        // Rumble on, then off again
        set_pad(12'hA5C, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
        send_frame(32'h0040_0301, 24);
        expect_reply("poll_rumble_on", 64, 64'h1CD2_1234_5678_9ABC, 1'b0, lat);
        chk("rumble_on", bus.rumble, 64'd1);
        send_frame(32'h0040_0300, 24);
        expect_reply("poll_rumble_off", 64, 64'h1CD2_1234_5678_9ABC, 1'b0, lat);
        chk("rumble_off", bus.rumble, 64'd0);

        // Identify
        s0 = n_strobe;
        send_frame(32'h0000_0000, 8);
        expect_reply("identify", 24, 64'h0000_0000_0009_0003, 1'b0, lat);
        chk("identify_no_strobe", 64'(n_strobe - s0), 64'd0);

        // Unknown command
        e0 = n_err; o0 = n_oe;
        send_frame(32'h0000_0041, 8);
        repeat (8 * CPU) @(negedge clk);
        chk("unknown_cmd_error", 64'(n_err - e0), 64'd1);
        chk("unknown_no_reply", 64'(n_oe - o0), 64'd0);

        // Overlong 30-bit frame
        e0 = n_err; o0 = n_oe;
        send_frame(32'h2AAA_AAAA, 30);
        repeat (8 * CPU) @(negedge clk);
        chk("long_frame_cmd_error", 64'(n_err - e0), 64'd1);
        chk("long_frame_no_reply", 64'(n_oe - o0), 64'd0);
        send_frame(32'h0040_0300, 24);
        expect_reply("poll_after_errors", 64, 64'h1CD2_1234_5678_9ABC, 1'b0, lat);

        // Line held low for 12 us
        e0 = n_err; o0 = n_oe; first = -1;
        host_low = 1'b1;
        for (int i = 1; i <= 12 * CPU; i++) begin
            @(negedge clk);
            if (bus.cmd_error === 1'b1 && first < 0) first = i;
        end
        host_low = 1'b0;
        chk("stuck_low_error_time", 64'((first >= 10 * CPU) && (first <= 10 * CPU + 10)), 64'd1);
        repeat (8 * CPU) @(negedge clk);
        chk("stuck_low_error_count", 64'(n_err - e0), 64'd1);
        chk("stuck_low_no_reply", 64'(n_oe - o0), 64'd0);
        send_frame(32'h0040_0300, 24);
        expect_reply("poll_after_fault", 64, 64'h1CD2_1234_5678_9ABC, 1'b0, lat);

        // Reset in the middle of a reply (bit 20)
        send_frame(32'h0040_0301, 24);
        t = 0;
        while (bus.data_oe !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("midreply_started", bus.data_oe, 64'd1);
        chk("midreply_rumble_set", bus.rumble, 64'd1);
        repeat (20 * 4 * CPU + 3) @(negedge clk);
        chk("midreply_bit20_low", bus.data_oe, 64'd1);
        reset = 1'b1;
        #1;
        chk("midreply_reset_oe", bus.data_oe, 64'd0);
        chk("midreply_reset_rumble", bus.rumble, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4 * CPU) @(negedge clk);
        chk("post_reset_idle", bus.data_oe, 64'd0);
        set_pad(12'h001, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(32'h0040_0300, 24);
        expect_reply("poll_after_reset", 64, 64'h0180_807F_0000_0000, 1'b0, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
